pipe_skid_stage: RTL and testbench

- Parametrised elastic pipeline stage register. It replaces fixed load-enabled stage latches between IF/ID/EX/MEM/WB.
- Carries an opaque payload (a packed stage struct) under a valid/ready handshake.
- Optional 2-entry skid buffer breaks the combinational ready path; synchronous flush kills in-flight entries on misprediction.
- Saturating stall counter for performance monitoring.

---
 rtl/pipe_skid_stage_pkg.sv | 45 ++++
 rtl/pipe_skid_stage_sat_counter.sv | 21 ++
 rtl/pipe_skid_stage.sv | 98 +++++++++
 tb/tb_pipe_skid_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline types: stage payload structs and the skid-stage state encoding.
package pipe_skid_stage_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] st_data;
    logic [4:0]      rd;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_data;
    logic [4:0]      rd;
    logic            reg_wr;
  } mem_wb_t;

  // Encoding is {out_valid, skid_valid} so both flags read straight off the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter used for performance monitors; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count on inc, hold once every bit is set, synchronous clear.
  always_ff @(posedge clk) begin
    if (rst)                 cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W   = 256,
  parameter bit                SKID_EN  = 1'b1,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer, out_xfer;

  assign out_valid_o = state_q[1];
  assign out_data_o  = main_q;
  // EMPTY=0, FULL=1, SKID=2 entries.
  assign occupancy_o = {state_q[1] & state_q[0], state_q[1] ^ state_q[0]};

  // With the skid buffer, ready comes only from the skid flag so out_ready
  // never reaches in_ready combinationally; without it, pass-through ready.
  assign in_ready_o = SKID_EN ? !state_q[0] : (!state_q[1] || out_ready_i);

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  // Next state and payload moves; flush empties the stage but leaves payload regs alone.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = FULL;
            main_d  = in_data_i;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            // Only reachable with the skid buffer: downstream stalled, park the new beat.
            state_d = SKID;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_ready_i) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid_o && !out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench: instance A has the skid buffer (4-bit stall counter),
// instance B is the single-register variant.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam logic [DW-1:0] A_RST = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst, flush;
  logic a_iv, a_ir, a_ov, a_or;
  logic [DW-1:0] a_id, a_od;
  logic [1:0] a_occ;
  logic [3:0] a_cnt;
  logic b_iv, b_ir, b_ov, b_or;
  logic [DW-1:0] b_id, b_od;
  logic [1:0] b_occ;
  logic [15:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(4), .RST_DATA(A_RST)) u_a (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
    .occupancy_o(a_occ), .stall_cnt_o(a_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
    .occupancy_o(b_occ), .stall_cnt_o(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    a_iv = 1'b0; a_or = 1'b0; a_id = '0;
    b_iv = 1'b0; b_or = 1'b0; b_id = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (a_ov !== 1'b0)   begin n_err++; $display("FAIL rst_ov got %b want 0", a_ov); end
    n_vec++; if (a_od !== A_RST)  begin n_err++; $display("FAIL rst_data got %h want %h", a_od, A_RST); end
    n_vec++; if (a_occ !== 2'd0)  begin n_err++; $display("FAIL rst_occ got %0d want 0", a_occ); end
    n_vec++; if (a_cnt !== 4'd0)  begin n_err++; $display("FAIL rst_cnt got %0d want 0", a_cnt); end
    n_vec++; if (a_ir !== 1'b1)   begin n_err++; $display("FAIL rst_ir got %b want 1", a_ir); end
    n_vec++; if (b_od !== 32'h0)  begin n_err++; $display("FAIL rst_b_data got %h want 0", b_od); end
  endtask

  task automatic test_single();
    a_iv = 1'b1; a_id = 32'hA5; a_or = 1'b1;
    #1;
    n_vec++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL single_ir0 got %b want 1", a_ir); end
    tick();
    a_iv = 1'b0;
    #1;
    n_vec++; if (a_ov !== 1'b1)   begin n_err++; $display("FAIL single_ov got %b want 1", a_ov); end
    n_vec++; if (a_od !== 32'hA5) begin n_err++; $display("FAIL single_data got %h want a5", a_od); end
    n_vec++; if (a_ir !== 1'b1)   begin n_err++; $display("FAIL single_ir1 got %b want 1", a_ir); end
    tick();
    n_vec++; if (a_ov !== 1'b0)   begin n_err++; $display("FAIL single_drain got %b want 0", a_ov); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_id = i + 1; a_or = 1'b1;
      b_iv = 1'b1; b_id = i + 1; b_or = 1'b1;
      tick();
      n_vec++; if (a_ov !== 1'b1 || a_od !== DW'(i + 1) || a_occ !== 2'd1)
        begin n_err++; $display("FAIL b2b_a[%0d] got v=%b d=%h o=%0d want 1 %h 1", i, a_ov, a_od, a_occ, i + 1); end
      n_vec++; if (b_ov !== 1'b1 || b_od !== DW'(i + 1) || b_occ !== 2'd1)
        begin n_err++; $display("FAIL b2b_b[%0d] got v=%b d=%h o=%0d want 1 %h 1", i, b_ov, b_od, b_occ, i + 1); end
    end
    a_iv = 1'b0; b_iv = 1'b0;
    tick();
    n_vec++; if (a_ov !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL b2b_a_end got v=%b o=%0d want 0 0", a_ov, a_occ); end
    n_vec++; if (b_ov !== 1'b0 || b_occ !== 2'd0) begin n_err++; $display("FAIL b2b_b_end got v=%b o=%0d want 0 0", b_ov, b_occ); end
  endtask

  task automatic test_skid();
    a_or = 1'b0;
    a_iv = 1'b1; a_id = 32'h10; tick();
    a_id = 32'h11; tick();
    a_iv = 1'b0; #1;
    n_vec++; if (a_occ !== 2'd2)  begin n_err++; $display("FAIL skid_occ got %0d want 2", a_occ); end
    n_vec++; if (a_ir !== 1'b0)   begin n_err++; $display("FAIL skid_ir got %b want 0", a_ir); end
    n_vec++; if (a_od !== 32'h10) begin n_err++; $display("FAIL skid_hold got %h want 10", a_od); end
    tick();
    n_vec++; if (a_od !== 32'h10 || a_occ !== 2'd2) begin n_err++; $display("FAIL skid_stall got %h/%0d want 10/2", a_od, a_occ); end
    a_or = 1'b1; #1;
    n_vec++; if (a_ir !== 1'b0)   begin n_err++; $display("FAIL skid_ir_comb got %b want 0", a_ir); end
    tick();
    n_vec++; if (a_od !== 32'h11 || a_ov !== 1'b1) begin n_err++; $display("FAIL skid_pop2 got %h v=%b want 11 1", a_od, a_ov); end
    n_vec++; if (a_ir !== 1'b1 || a_occ !== 2'd1)  begin n_err++; $display("FAIL skid_ir_back got %b o=%0d want 1 1", a_ir, a_occ); end
    tick();
    n_vec++; if (a_ov !== 1'b0)   begin n_err++; $display("FAIL skid_empty got %b want 0", a_ov); end
  endtask

  task automatic test_flush();
    a_or = 1'b0;
    a_iv = 1'b1; a_id = 32'h20; tick();
    a_id = 32'h21; tick();
    flush = 1'b1; a_id = 32'h77; tick();
    flush = 1'b0; a_iv = 1'b0; #1;
    n_vec++; if (a_ov !== 1'b0 || a_occ !== 2'd0 || a_ir !== 1'b1)
      begin n_err++; $display("FAIL flush_skid got v=%b o=%0d r=%b want 0 0 1", a_ov, a_occ, a_ir); end
    // Flush while FULL with an accepted input: that input is dropped too.
    a_iv = 1'b1; a_id = 32'h30; tick();
    flush = 1'b1; a_id = 32'h78; tick();
    flush = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL flush_ghost[%0d] got v=%b d=%h want v=0", i, a_ov, a_od); end
      tick();
    end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    a_iv = 1'b1; a_id = 32'h40; a_or = 1'b0; tick();
    a_iv = 1'b0;
    n_vec++; if (a_cnt !== 4'd0)  begin n_err++; $display("FAIL cnt_start got %0d want 0", a_cnt); end
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (a_cnt !== 4'd5)  begin n_err++; $display("FAIL cnt_5 got %0d want 5", a_cnt); end
    for (int i = 0; i < 15; i++) tick();
    n_vec++; if (a_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_sat got %0d want 15", a_cnt); end
    n_vec++; if (a_od !== 32'h40) begin n_err++; $display("FAIL cnt_data got %h want 40", a_od); end
    flush = 1'b1; tick(); flush = 1'b0; tick();
    n_vec++; if (a_cnt !== 4'd15 || a_ov !== 1'b0) begin n_err++; $display("FAIL cnt_flush got %0d v=%b want 15 0", a_cnt, a_ov); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_vec++; if (a_cnt !== 4'd0)  begin n_err++; $display("FAIL cnt_rst got %0d want 0", a_cnt); end
  endtask

  task automatic test_noskid();
    do_reset();
    b_iv = 1'b1; b_id = 32'h50; b_or = 1'b0; tick();
    b_id = 32'h51; #1;
    n_vec++; if (b_ir !== 1'b0)   begin n_err++; $display("FAIL ns_ir_stall got %b want 0", b_ir); end
    tick();
    n_vec++; if (b_od !== 32'h50 || b_ov !== 1'b1) begin n_err++; $display("FAIL ns_hold got %h v=%b want 50 1", b_od, b_ov); end
    n_vec++; if (b_cnt !== 16'd1) begin n_err++; $display("FAIL ns_cnt got %0d want 1", b_cnt); end
    b_or = 1'b1; #1;
    n_vec++; if (b_ir !== 1'b1)   begin n_err++; $display("FAIL ns_ir_comb got %b want 1", b_ir); end
    tick();
    b_iv = 1'b0; #1;
    n_vec++; if (b_od !== 32'h51 || b_ov !== 1'b1 || b_occ !== 2'd1)
      begin n_err++; $display("FAIL ns_next got %h v=%b o=%0d want 51 1 1", b_od, b_ov, b_occ); end
    tick();
    n_vec++; if (b_ov !== 1'b0 || b_occ !== 2'd0) begin n_err++; $display("FAIL ns_drain got v=%b o=%0d want 0 0", b_ov, b_occ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_stall_cnt();
    test_noskid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got stuck want finish");
    $fatal(1);
  end

endmodule
